// File: rtl/xfer_pkg.sv
// Shared types and helpers for the pair transfer engine.
package xfer_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    ModeSel     = 2'b00,
    ModeAdd     = 2'b01,
    ModeSub     = 2'b10,
    ModeAbsdiff = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    StIdle,
    StRd0,
    StRd1,
    StWr,
    StDone
  } state_t;

  // Index width that never collapses to zero bits for single-entry memories.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pair_xfer_engine_if.sv
// Host-side handshake, load and readback signals of the pair transfer engine.
interface pair_xfer_engine_if
  import xfer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) ();

  localparam int unsigned AW = idx_w(DEPTH);
  localparam int unsigned KW = idx_w(DEPTH / 2);
  localparam int unsigned CW = $clog2(DEPTH / 2) + 1;

  logic              start;
  logic [MODE_W-1:0] mode;
  logic              ld_we;
  logic [AW-1:0]     ld_addr;
  logic [WIDTH-1:0]  ld_data;
  logic [KW-1:0]     rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              busy;
  logic              done;
  logic [CW-1:0]     count;

  modport master (
    output start, mode, ld_we, ld_addr, ld_data, rd_addr,
    input  rd_data, busy, done, count
  );

  modport slave (
    input  start, mode, ld_we, ld_addr, ld_data, rd_addr,
    output rd_data, busy, done, count
  );

endinterface

// File: rtl/xfer_alu.sv
// Combinational pair reducer: one result per (a, b) under the selected mode,
// evaluated in WIDTH+1 bits with optional saturation.
module xfer_alu
  import xfer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SAT   = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  mode_t            mode,
  output logic [WIDTH-1:0] result
);

  localparam bit Sat = (SAT != 0);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] abs_res;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    // Carry out of sum means overflow; borrow out of diff means a < b.
    add_res = (Sat && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    sub_res = (Sat && diff[WIDTH]) ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
    abs_res = diff[WIDTH] ? (b - a) : diff[WIDTH-1:0];
    result  = '0;
    unique case (mode)
      ModeSel:     result = (a > b) ? diff[WIDTH-1:0] : add_res;
      ModeAdd:     result = add_res;
      ModeSub:     result = sub_res;
      ModeAbsdiff: result = abs_res;
    endcase
  end

endmodule

// File: rtl/pair_xfer_engine.sv
// Memory-to-memory pair reducer: src[2k], src[2k+1] -> dst[k], three cycles per
// pair, with start/busy/done handshake and a host readback port on dst.
module pair_xfer_engine
  import xfer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SAT   = 0
) (
  input logic               clock,
  input logic               Reset,
  pair_xfer_engine_if.slave bus
);

  localparam int unsigned AW    = idx_w(DEPTH);
  localparam int unsigned KW    = idx_w(DEPTH / 2);
  localparam int unsigned CW    = $clog2(DEPTH / 2) + 1;
  localparam int unsigned Pairs = DEPTH / 2;

  localparam logic [KW-1:0] LastK = KW'(Pairs - 1);

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q;
  logic [CW-1:0]    count_q;
  mode_t            mode_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] src_q;
  logic [WIDTH-1:0] rd_q;
  logic [WIDTH-1:0] alu_res;
  logic             rd_odd;
  logic [AW-1:0]    src_raddr;
  logic             accept;

  logic [WIDTH-1:0] src_mem [DEPTH];
  logic [WIDTH-1:0] dst_mem [Pairs];

  always_comb begin
    state_d = state_q;
    rd_odd  = 1'b0;
    unique case (state_q)
      StIdle: if (bus.start) state_d = StRd0;
      StRd0:  state_d = StRd1;
      StRd1: begin
        rd_odd  = 1'b1;
        state_d = StWr;
      end
      StWr:   state_d = (k_q == LastK) ? StDone : StRd0;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign accept    = (state_q == StIdle) && bus.start;
  assign src_raddr = AW'({k_q, rd_odd});

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q <= StIdle;
      k_q     <= '0;
      count_q <= '0;
      mode_q  <= ModeSel;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        k_q     <= '0;
        count_q <= '0;
        mode_q  <= mode_t'(bus.mode);
      end
      if (state_q == StRd1) begin
        a_q <= src_q;
      end
      if (state_q == StWr) begin
        k_q     <= k_q + KW'(1);
        count_q <= count_q + CW'(1);
      end
    end
  end

  // Memories are never cleared; Reset only blocks writes so an abort is immediate.
  always_ff @(posedge clock) begin
    if (!Reset && (state_q == StIdle) && bus.ld_we) begin
      src_mem[bus.ld_addr] <= bus.ld_data;
    end
    src_q <= src_mem[src_raddr];
    if (!Reset && (state_q == StWr)) begin
      dst_mem[k_q] <= alu_res;
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      rd_q <= '0;
    end else begin
      rd_q <= dst_mem[bus.rd_addr];
    end
  end

  xfer_alu #(
    .WIDTH (WIDTH),
    .SAT   (SAT)
  ) u_alu (
    .a      (a_q),
    .b      (src_q),
    .mode   (mode_q),
    .result (alu_res)
  );

  assign bus.rd_data = rd_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = (state_q == StDone);
  assign bus.count   = count_q;

endmodule
